// File: rtl/if_stage_fq.sv
// Instruction-fetch stage with a decoupled prefetch FIFO feeding the IF/ID register.
// One memory request in flight at most; EX redirects discard queued and in-flight fetches.
module if_stage_fq #(
  parameter int unsigned          XLEN     = 32,
  parameter int unsigned          DEPTH    = 4,
  parameter logic [XLEN-1:0]      RESET_PC = '0
) (
  input  logic                      CLK,
  input  logic                      Clr,
  input  logic                      PCSrcE,
  input  logic [XLEN-1:0]           PCTargetE,
  input  logic                      StallD,
  input  logic                      FlushD,
  output logic                      ImemReq,
  output logic [XLEN-1:0]           ImemAddr,
  input  logic                      ImemGnt,
  input  logic                      ImemRvalid,
  input  logic [31:0]               ImemRdata,
  output logic [31:0]               InstrD,
  output logic [XLEN-1:0]           PCD,
  output logic [XLEN-1:0]           PCPlus4D,
  output logic                      ValidD,
  output logic [$clog2(DEPTH):0]    FqCount
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic            out_q, out_d;
  logic            drop_q, drop_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] fpc_q [DEPTH];
  logic [31:0]     fins_q [DEPTH];

  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pcd_q, pcd_d;
  logic [XLEN-1:0] pcp4_q, pcp4_d;
  logic            valid_q, valid_d;

  logic resp, push, pop, space, grant;

  assign resp  = out_q & ImemRvalid;
  assign push  = resp & ~drop_q & ~PCSrcE;
  // A response retiring this cycle frees the single slot, so a new grant can
  // overlap it; the occupancy check includes the entry that response pushes.
  assign space = (cnt_q + CW'(push)) < CW'(DEPTH);
  assign ImemReq  = ~PCSrcE & (~out_q | ImemRvalid) & space;
  assign ImemAddr = pcf_q;
  assign grant    = ImemReq & ImemGnt;
  assign pop      = ~PCSrcE & ~FlushD & ~StallD & (cnt_q != '0);

  always_comb begin
    pcf_d  = pcf_q;
    ipc_d  = ipc_q;
    out_d  = out_q;
    drop_d = drop_q;
    wptr_d = wptr_q + AW'(push);
    rptr_d = rptr_q + AW'(pop);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    if (PCSrcE) begin
      pcf_d  = PCTargetE;
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else if (grant) begin
      pcf_d = pcf_q + XLEN'(4);
      ipc_d = pcf_q;
    end
    if (grant) begin
      out_d = 1'b1;
    end else if (resp) begin
      out_d = 1'b0;
    end
    if (resp) begin
      drop_d = 1'b0;
    end else if (PCSrcE && out_q) begin
      drop_d = 1'b1;
    end
  end

  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (PCSrcE) begin
      valid_d = 1'b0;
      instr_d = NOP;
    end else if (FlushD) begin
      valid_d = 1'b0;
      instr_d = NOP;
      pcd_d   = '0;
      pcp4_d  = '0;
    end else if (!StallD) begin
      if (cnt_q != '0) begin
        valid_d = 1'b1;
        instr_d = fins_q[rptr_q];
        pcd_d   = fpc_q[rptr_q];
        pcp4_d  = fpc_q[rptr_q] + XLEN'(4);
      end else begin
        valid_d = 1'b0;
        instr_d = NOP;
      end
    end
  end

  always_ff @(posedge CLK or negedge Clr) begin
    if (!Clr) begin
      pcf_q   <= RESET_PC;
      ipc_q   <= '0;
      out_q   <= 1'b0;
      drop_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      instr_q <= NOP;
      pcd_q   <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pcf_q   <= pcf_d;
      ipc_q   <= ipc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fpc_q[wptr_q]  <= ipc_q;
      fins_q[wptr_q] <= ImemRdata;
    end
  end

  assign InstrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pcp4_q;
  assign ValidD   = valid_q;
  assign FqCount  = cnt_q;

endmodule

// File: tb/tb_if_stage_fq.sv
// Bench for if_stage_fq: queue-based reference model checked every cycle,
// a variable-latency memory responder, and directed scenarios with literal checks.
module tb_if_stage_fq;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h100;
  localparam logic [31:0] NOP   = 32'h13;

  logic        CLK = 0, Clr = 0, PCSrcE = 0, StallD = 0, FlushD = 0;
  logic        ImemGnt = 0, ImemRvalid = 0;
  logic [31:0] PCTargetE = 0, ImemRdata = 0;
  logic        ImemReq, ValidD;
  logic [31:0] ImemAddr, InstrD, PCD, PCPlus4D;
  logic [2:0]  FqCount;

  if_stage_fq #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h100)) dut (
    .CLK(CLK), .Clr(Clr), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .StallD(StallD), .FlushD(FlushD), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
    .ImemGnt(ImemGnt), .ImemRvalid(ImemRvalid), .ImemRdata(ImemRdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .FqCount(FqCount)
  );

  always #5 CLK = ~CLK;

  int tests = 0, fails = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC000_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: fetched pairs live in a plain queue
  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_pcf, m_ipc, m_instr, m_pcd, m_pcp4;
  bit          m_out, m_drop, m_valid;

  function automatic bit m_req();
    int pend;
    pend = (m_out && ImemRvalid && !m_drop) ? 1 : 0;
    return !PCSrcE && (!m_out || ImemRvalid) && (m_q.size() + pend < DEPTH);
  endfunction

  always @(posedge CLK or negedge Clr) begin
    bit   req, resp, gnt;
    int   had;
    ent_t e;
    if (!Clr) begin
      m_q.delete();
      m_pcf = RPC; m_ipc = 0; m_out = 0; m_drop = 0;
      m_valid = 0; m_instr = NOP; m_pcd = 0; m_pcp4 = 0;
    end else begin
      req  = m_req();
      resp = m_out && ImemRvalid;
      gnt  = req && ImemGnt;
      if (PCSrcE) begin
        m_q.delete();
        m_pcf = PCTargetE; m_valid = 0; m_instr = NOP;
        if (resp) begin m_out = 0; m_drop = 0; end
        else if (m_out) m_drop = 1;
      end else begin
        had = m_q.size();
        if (FlushD) begin
          m_valid = 0; m_instr = NOP; m_pcd = 0; m_pcp4 = 0;
        end else if (!StallD) begin
          if (had > 0) begin
            e = m_q.pop_front();
            m_valid = 1; m_instr = e.ins; m_pcd = e.pc; m_pcp4 = e.pc + 4;
          end else begin
            m_valid = 0; m_instr = NOP;
          end
        end
        if (resp && !m_drop) m_q.push_back({m_ipc, ImemRdata});
        if (resp) begin m_out = 0; m_drop = 0; end
        if (gnt) begin m_out = 1; m_ipc = m_pcf; m_pcf = m_pcf + 4; end
      end
    end
  end

  // Compare against the model and snapshot the handshake for the responder
  bit          s_grant, s_rv;
  logic [31:0] s_addr;
  logic [31:0] g_addrs[$];
  always @(negedge CLK) begin
    check("ImemReq",  {31'b0, ImemReq}, {31'b0, m_req()});
    check("ImemAddr", ImemAddr, m_pcf);
    check("FqCount",  {29'b0, FqCount}, 32'(m_q.size()));
    check("ValidD",   {31'b0, ValidD}, {31'b0, m_valid});
    check("InstrD",   InstrD, m_instr);
    check("PCD",      PCD, m_pcd);
    check("PCPlus4D", PCPlus4D, m_pcp4);
    s_grant = ImemReq && ImemGnt && Clr;
    s_rv    = ImemRvalid;
    s_addr  = ImemAddr;
    if (s_grant) g_addrs.push_back(ImemAddr);
  end

  // Memory responder: Rvalid 'lat' cycles after the grant, held until taken
  int          lat = 1;
  bit          r_act = 0;
  int          r_wait = 0;
  logic [31:0] r_addr = 0;
  always @(posedge CLK) begin
    #1;
    if (s_rv && r_act) r_act = 0;
    if (s_grant) begin r_act = 1; r_wait = lat; r_addr = s_addr; end
    if (r_act && r_wait <= 1) begin
      ImemRvalid = 1; ImemRdata = instr_of(r_addr);
    end else begin
      if (r_act) r_wait--;
      ImemRvalid = 0; ImemRdata = 32'hDEAD_BEEF;
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge CLK);
      if (ValidD) seen = 1;
    end
    check({name, "_seen"}, {31'b0, seen}, 32'd1);
    check({name, "_PCD"}, PCD, exp_pc);
    check({name, "_InstrD"}, InstrD, instr_of(exp_pc));
    check({name, "_PCPlus4D"}, PCPlus4D, exp_pc + 4);
  endtask

  task automatic wait_grant(input string name, input int min_cnt);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge CLK);
      if (ImemReq && ImemGnt && FqCount >= 3'(min_cnt)) seen = 1;
    end
    check({name, "_grant"}, {31'b0, seen}, 32'd1);
  endtask

  initial begin
    ImemGnt = 1;
    repeat (2) tick();
    check("rst_ValidD", {31'b0, ValidD}, 32'd0);
    check("rst_InstrD", InstrD, NOP);
    check("rst_FqCount", {29'b0, FqCount}, 32'd0);
    check("rst_ImemAddr", ImemAddr, 32'h100);
    check("rst_PCD", PCD, 32'd0);
    Clr = 1;

    // Startup stream
    wait_valid("first", 32'h100);
    check("addr0", g_addrs[0], 32'h100);
    check("addr1", g_addrs[1], 32'h104);
    check("addr2", g_addrs[2], 32'h108);
    repeat (4) tick();

    // Stall saturates the queue, then flush+stall bubbles without popping
    StallD = 1;
    repeat (6) tick();
    check("stall_FqCount", {29'b0, FqCount}, 32'd4);
    check("stall_ImemReq", {31'b0, ImemReq}, 32'd0);
    FlushD = 1;
    tick();
    FlushD = 0;
    check("flush_ValidD", {31'b0, ValidD}, 32'd0);
    check("flush_InstrD", InstrD, NOP);
    check("flush_FqCount", {29'b0, FqCount}, 32'd4);
    check("flush_PCD", PCD, 32'd0);
    StallD = 0;
    repeat (8) tick();

    // Redirect with a slow request in flight
    lat = 3;
    wait_grant("redir", 0);
    tick();
    PCSrcE = 1; PCTargetE = 32'h200;
    tick();
    PCSrcE = 0;
    check("redir_FqCount", {29'b0, FqCount}, 32'd0);
    check("redir_ImemAddr", ImemAddr, 32'h200);
    check("redir_ImemReq", {31'b0, ImemReq}, 32'd0);
    wait_valid("redir", 32'h200);
    lat = 1;
    repeat (4) tick();

    // Redirect in the same cycle as a response
    wait_grant("same", 0);
    tick();
    PCSrcE = 1; PCTargetE = 32'h300;
    tick();
    PCSrcE = 0;
    check("same_ValidD", {31'b0, ValidD}, 32'd0);
    check("same_FqCount", {29'b0, FqCount}, 32'd0);
    wait_valid("same", 32'h300);
    repeat (3) tick();

    // Async reset with a backed-up queue and a request in flight
    StallD = 1; lat = 3;
    wait_grant("rst2", 2);
    @(posedge CLK); #3;
    Clr = 0; ImemGnt = 0;
    #1;
    check("rst2_ValidD", {31'b0, ValidD}, 32'd0);
    check("rst2_FqCount", {29'b0, FqCount}, 32'd0);
    check("rst2_ImemAddr", ImemAddr, RPC);
    check("rst2_InstrD", InstrD, NOP);
    tick();
    Clr = 1; StallD = 0;
    repeat (5) tick();
    check("stale_FqCount", {29'b0, FqCount}, 32'd0);
    check("stale_ValidD", {31'b0, ValidD}, 32'd0);
    check("stale_ImemReq", {31'b0, ImemReq}, 32'd1);
    check("stale_ImemAddr", ImemAddr, RPC);
    lat = 1; ImemGnt = 1;
    wait_valid("after_rst", 32'h100);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
